bcd_conv_ctrl: RTL

BCD_CONV_CTRL -- requirements
Module: bcd_conv_ctrl

---
 rtl/bcd_conv_pkg.sv | 17 +
 rtl/dd_add3.sv | 13 +
 rtl/bcd_conv_ctrl.sv | 103 ++++++++++
 3 files changed

// File: rtl/bcd_conv_pkg.sv
// Shared types and sizing for the binary-to-BCD converter.
// The converter uses shift-and-add-3 (double dabble).
package bcd_conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int ITER_CNT = 8;
  localparam int BIN_W    = 8;
  localparam int BCD_W    = 12;
  localparam int WORK_W   = BCD_W + BIN_W;
  localparam int CNT_W    = $clog2(ITER_CNT);

endpackage

// File: rtl/dd_add3.sv
// Double-dabble nibble correction: add 3 when the digit is 5 or more.
// Inputs 5..9 map to 8..12, so 4-bit arithmetic never wraps.
module dd_add3 (
  input  logic [3:0] d,
  output logic [3:0] q
);

  always_comb begin
    q = d;
    if (d >= 4'd5) q = d + 4'd3;
  end

endmodule

// File: rtl/bcd_conv_ctrl.sv
// Converts an 8-bit binary value to 3-digit BCD, one double-dabble step per
// clock, with valid/ready handshakes on both the input and the result sides.
module bcd_conv_ctrl
  import bcd_conv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BIN_W-1:0]  b_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BCD_W-1:0]  bcd_out,
  output logic              busy
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_SHIFT = SHIFT;
  localparam logic [1:0] ST_DONE  = DONE;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER_CNT - 1);

  logic [1:0]        state_q, state_d;
  logic [WORK_W-1:0] work_q, work_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;

  logic [WORK_W-1:0] corrected;
  logic [WORK_W-1:0] shifted;
  logic              accept;

  // Only the three BCD nibbles are corrected; the binary tail passes through.
  assign corrected[BIN_W-1:0] = work_q[BIN_W-1:0];

  dd_add3 u_add3_units (.d(work_q[11:8]),  .q(corrected[11:8]));
  dd_add3 u_add3_tens  (.d(work_q[15:12]), .q(corrected[15:12]));
  dd_add3 u_add3_hunds (.d(work_q[19:16]), .q(corrected[19:16]));

  assign shifted = corrected << 1;

  assign in_ready  = !clear && (state_q == ST_IDLE ||
                                (state_q == ST_DONE && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_SHIFT);
  assign bcd_out   = bcd_q;

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            work_d  = {{BCD_W{1'b0}}, b_in};
            cnt_d   = '0;
            state_d = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          work_d = shifted;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            bcd_d   = shifted[WORK_W-1:BIN_W];
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          // A new operand may be taken on the same edge the result leaves.
          if (out_ready) begin
            if (accept) begin
              work_d  = {{BCD_W{1'b0}}, b_in};
              cnt_d   = '0;
              state_d = ST_SHIFT;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
    end
  end

endmodule
